// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: hex decode, per-digit slots with dead time,
// PWM dimming, and double-buffered config that only changes at a frame boundary.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE   = 50000,
  parameter int DEAD       = 4,
  parameter int PWM_BITS   = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic                            scan_en,
  input  logic                            cfg_load,
  input  logic [4*NUM_DIGITS-1:0]         digit_data,
  input  logic [NUM_DIGITS-1:0]           dp_mask,
  input  logic [NUM_DIGITS-1:0]           digit_en,
  input  logic [PWM_BITS-1:0]             brightness,
  output logic                            cfg_pending,
  output logic                            frame_done,
  output logic [$clog2(NUM_DIGITS)-1:0]   cur_digit,
  output logic [7:0]                      seg_n,
  output logic [NUM_DIGITS-1:0]           an_n
);

  localparam int DW = $clog2(NUM_DIGITS);
  localparam int SW = $clog2(PRESCALE);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   en;
    logic [PWM_BITS-1:0]     br;
  } cfg_t;

  localparam cfg_t CFG_RST = '{data: '0, dp: '0, en: '0, br: '1};

  state_t                r_state, w_state_nxt;
  logic [SW-1:0]         r_sc;
  logic [DW-1:0]         r_cur;
  cfg_t                  r_act, r_pnd, w_in;
  logic                  r_pend;
  logic [7:0]            r_seg_n;
  logic [NUM_DIGITS-1:0] r_an_n;

  logic       w_scanning, w_sc_last, w_dig_last, w_boundary, w_pwm_on, w_lit;
  logic [3:0] w_nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign w_in = '{data: digit_data, dp: dp_mask, en: digit_en, br: brightness};

  // scan_en is folded in so a drop blanks the display on the very next edge
  assign w_scanning = (r_state == SCAN) && scan_en;
  assign w_sc_last  = (r_sc == SW'(PRESCALE - 1));
  assign w_dig_last = (r_cur == DW'(NUM_DIGITS - 1));
  assign w_boundary = (r_state == SCAN) && w_sc_last && w_dig_last;

  assign w_nib    = r_act.data[{r_cur, 2'b00} +: 4];
  assign w_pwm_on = (&r_act.br) || (r_sc[PWM_BITS-1:0] < r_act.br);
  assign w_lit    = w_scanning && (r_sc >= SW'(DEAD)) && r_act.en[r_cur] && w_pwm_on;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (scan_en)  w_state_nxt = SCAN;
      SCAN:    if (!scan_en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= IDLE;
    else                r_state <= w_state_nxt;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_sc  <= '0;
      r_cur <= '0;
    end else if (w_scanning) begin
      if (w_sc_last) begin
        r_sc  <= '0;
        r_cur <= w_dig_last ? '0 : r_cur + 1'b1;
      end else begin
        r_sc  <= r_sc + 1'b1;
      end
    end else begin
      r_sc  <= '0;
      r_cur <= '0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_an_n  <= '1;
      r_seg_n <= 8'hFF;
    end else if (w_lit) begin
      r_an_n  <= ~(NUM_DIGITS'(1) << r_cur);
      r_seg_n <= ~{r_act.dp[r_cur], hex7(w_nib)};
    end else begin
      r_an_n  <= '1;
      r_seg_n <= 8'hFF;
    end
  end

  // Leaving SCAN flushes pending (or takes a simultaneous load directly) so IDLE never holds a pending set
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_act  <= CFG_RST;
      r_pnd  <= CFG_RST;
      r_pend <= 1'b0;
    end else if (r_state == IDLE) begin
      if (cfg_load) r_act <= w_in;
    end else if (!scan_en) begin
      if (cfg_load)    r_act <= w_in;
      else if (r_pend) r_act <= r_pnd;
      r_pend <= 1'b0;
    end else begin
      if (w_boundary && r_pend) r_act <= r_pnd;
      if (cfg_load) begin
        r_pnd  <= w_in;
        r_pend <= 1'b1;
      end else if (w_boundary) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign cfg_pending = r_pend;
  assign frame_done  = w_boundary;
  assign cur_digit   = r_cur;
  assign seg_n       = r_seg_n;
  assign an_n        = r_an_n;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomized bench for sevenseg_scan_ctrl; expected outputs come from a timeline model
// (cycles since scan start -> slot/digit) plus explicit spot checks.
module tb_sevenseg_scan_ctrl;
  localparam int N = 8, P = 16, DEAD = 2, PB = 2, FR = N * P;

  logic clk = 1'b0, rst_n = 1'b0, scan_en = 1'b0, cfg_load = 1'b0;
  logic [31:0] digit_data = '0;
  logic [7:0]  dp_mask = '0, digit_en = '0;
  logic [1:0]  brightness = '0;
  logic        cfg_pending, frame_done;
  logic [2:0]  cur_digit;
  logic [7:0]  seg_n, an_n;

  sevenseg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .DEAD(DEAD), .PWM_BITS(PB)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .scan_en(scan_en), .cfg_load(cfg_load),
    .digit_data(digit_data), .dp_mask(dp_mask), .digit_en(digit_en), .brightness(brightness),
    .cfg_pending(cfg_pending), .frame_done(frame_done), .cur_digit(cur_digit),
    .seg_n(seg_n), .an_n(an_n));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [7:0] dp; logic [7:0] en; logic [1:0] br; } cfg_t;

  int n_chk = 0, n_fail = 0;
  logic [6:0] HEX [16];
  bit   m_run, m_pend;
  int   m_t;
  cfg_t m_a, m_p;
  logic [7:0] m_an, m_seg;

  function automatic logic [2:0] exp_cur();
    return m_run ? 3'((m_t / P) % N) : 3'd0;
  endfunction
  function automatic logic exp_fd();
    return m_run && (m_t % FR == FR - 1);
  endfunction

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_t = 0;
    m_a = '{d: '0, dp: '0, en: '0, br: 2'b11};
    m_p = m_a;
    m_an = 8'hFF; m_seg = 8'hFF;
  endtask

  // Advance one clock and update the model from the inputs seen at that edge; returns at negedge
  task automatic step();
    int sc, d;
    bit lit, bnd;
    cfg_t in;
    @(posedge clk);
    in = '{d: digit_data, dp: dp_mask, en: digit_en, br: brightness};
    sc = m_t % P;
    d  = (m_t / P) % N;
    lit = m_run && scan_en && sc >= DEAD && m_a.en[d] && (m_a.br == 2'b11 || (sc % 4) < m_a.br);
    if (lit) begin
      m_an  = ~(8'b1 << d);
      m_seg = ~{m_a.dp[d], HEX[m_a.d[4*d +: 4]]};
    end else begin
      m_an = 8'hFF; m_seg = 8'hFF;
    end
    bnd = m_run && scan_en && sc == P - 1 && d == N - 1;
    if (!m_run) begin
      if (cfg_load) m_a = in;
    end else if (!scan_en) begin
      if (cfg_load) m_a = in; else if (m_pend) m_a = m_p;
      m_pend = 0;
    end else begin
      if (bnd && m_pend) m_a = m_p;
      if (cfg_load) begin m_p = in; m_pend = 1; end
      else if (bnd) m_pend = 0;
    end
    if (!m_run) begin
      if (scan_en) begin m_run = 1; m_t = 0; end
    end else if (!scan_en) begin
      m_run = 0; m_t = 0;
    end else m_t++;
    @(negedge clk);
  endtask

  task automatic load(input cfg_t c);
    digit_data = c.d; dp_mask = c.dp; digit_en = c.en; brightness = c.br;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  function automatic cfg_t rnd_cfg();
    cfg_t c;
    c.d = $urandom; c.dp = 8'($urandom); c.en = 8'($urandom); c.br = 2'($urandom_range(0, 3));
    return c;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({an_n, seg_n, frame_done, cfg_pending, cur_digit} !== {8'hFF, 8'hFF, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=%h", {an_n, seg_n, frame_done, cfg_pending, cur_digit},
               {8'hFF, 8'hFF, 1'b0, 1'b0, 3'd0});
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    int pulses = 0;
    load('{d: 32'h76543210, dp: 8'h00, en: 8'hFF, br: 2'd3});
    n_chk++;
    if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL idle_load_pending got=%b want=0", cfg_pending); end
    scan_en = 1'b1;
    for (int i = 0; i < 2 * FR + 4; i++) begin
      step();
      n_chk++;
      if ({an_n, seg_n, frame_done, cfg_pending, cur_digit} !== {m_an, m_seg, exp_fd(), m_pend, exp_cur()}) begin
        n_fail++;
        $display("FAIL basic t=%0d got=%h want=%h", m_t, {an_n, seg_n, frame_done, cfg_pending, cur_digit},
                 {m_an, m_seg, exp_fd(), m_pend, exp_cur()});
      end
      if (frame_done) pulses++;
      if (m_t == 5) begin
        n_chk++;
        if ({an_n, seg_n} !== 16'hFEC0) begin n_fail++; $display("FAIL digit0 got=%h want=fec0", {an_n, seg_n}); end
      end
      if (m_t == P + 5) begin
        n_chk++;
        if ({an_n, seg_n} !== 16'hFDF9) begin n_fail++; $display("FAIL digit1 got=%h want=fdf9", {an_n, seg_n}); end
      end
    end
    n_chk++;
    if (pulses != 2) begin n_fail++; $display("FAIL frame_pulses got=%0d want=2", pulses); end
  endtask

  task automatic test_cfg_update();
    for (int i = 0; i < 2 * FR && exp_cur() != 3; i++) step();
    load('{d: 32'h0000000F, dp: 8'h00, en: 8'hFF, br: 2'd3});
    n_chk++;
    if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL pending_set got=%b want=1", cfg_pending); end
    for (int i = 0; i < FR + 8; i++) begin
      step();
      n_chk++;
      if ({an_n, seg_n, frame_done, cfg_pending, cur_digit} !== {m_an, m_seg, exp_fd(), m_pend, exp_cur()}) begin
        n_fail++;
        $display("FAIL cfg_update t=%0d got=%h want=%h", m_t, {an_n, seg_n, frame_done, cfg_pending, cur_digit},
                 {m_an, m_seg, exp_fd(), m_pend, exp_cur()});
      end
      if (m_t % FR == 5) begin
        n_chk++;
        if ({an_n, seg_n, cfg_pending} !== {8'hFE, 8'h8E, 1'b0}) begin
          n_fail++; $display("FAIL new_frame_digit0 got=%h want=%h", {an_n, seg_n, cfg_pending}, {8'hFE, 8'h8E, 1'b0});
        end
      end
    end
  endtask

  task automatic test_pwm();
    int lows_tab[4] = '{0, 24, 48, 112};
    logic [1:0] brs[4];
    int lows;
    brs[0] = 2'd1; brs[1] = 2'd0; brs[2] = 2'd3; brs[3] = 2'($urandom_range(0, 3));
    for (int k = 0; k < 4; k++) begin
      load('{d: $urandom, dp: 8'($urandom), en: 8'hFF, br: brs[k]});
      for (int i = 0; i < 2 * FR && m_pend; i++) step();
      lows = 0;
      for (int i = 0; i < FR; i++) begin
        step();
        n_chk++;
        if ({an_n, seg_n, frame_done, cfg_pending, cur_digit} !== {m_an, m_seg, exp_fd(), m_pend, exp_cur()}) begin
          n_fail++;
          $display("FAIL pwm br=%0d t=%0d got=%h want=%h", brs[k], m_t, {an_n, seg_n, frame_done, cfg_pending, cur_digit},
                   {m_an, m_seg, exp_fd(), m_pend, exp_cur()});
        end
        if (an_n != 8'hFF) lows++;
      end
      n_chk++;
      if (lows != lows_tab[brs[k]]) begin
        n_fail++; $display("FAIL pwm_duty br=%0d got=%0d want=%0d", brs[k], lows, lows_tab[brs[k]]);
      end
    end
  endtask

  task automatic test_mask();
    int lows = 0, last = -1, per_bad = 0;
    load('{d: $urandom, dp: 8'h01, en: 8'h05, br: 2'd3});
    for (int i = 0; i < 2 * FR && m_pend; i++) step();
    for (int i = 0; i < 2 * FR + 4; i++) begin
      step();
      n_chk++;
      if ({an_n, seg_n, frame_done, cfg_pending, cur_digit} !== {m_an, m_seg, exp_fd(), m_pend, exp_cur()}) begin
        n_fail++;
        $display("FAIL mask t=%0d got=%h want=%h", m_t, {an_n, seg_n, frame_done, cfg_pending, cur_digit},
                 {m_an, m_seg, exp_fd(), m_pend, exp_cur()});
      end
      if (i < FR && an_n != 8'hFF) lows++;
      if ((an_n == 8'hFE && seg_n[7] !== 1'b0) || (an_n == 8'hFB && seg_n[7] !== 1'b1) ||
          (an_n != 8'hFF && an_n != 8'hFE && an_n != 8'hFB)) per_bad++;
      if (frame_done) begin
        if (last >= 0 && i - last != FR) per_bad++;
        last = i;
      end
    end
    n_chk++;
    if (lows != 28) begin n_fail++; $display("FAIL mask_lit_cycles got=%0d want=28", lows); end
    n_chk++;
    if (per_bad != 0) begin n_fail++; $display("FAIL mask_shape_period got=%0d bad want=0", per_bad); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2 * FR && exp_cur() != 2; i++) step();
    load(rnd_cfg());
    repeat (10) step();
    load(rnd_cfg());
    for (int i = 0; i < 2 * FR && (m_t % FR) != FR - 1; i++) step();
    load(rnd_cfg());
    n_chk++;
    if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL boundary_load_pending got=%b want=1", cfg_pending); end
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      n_chk++;
      if ({an_n, seg_n, frame_done, cfg_pending, cur_digit} !== {m_an, m_seg, exp_fd(), m_pend, exp_cur()}) begin
        n_fail++;
        $display("FAIL back_to_back t=%0d got=%h want=%h", m_t, {an_n, seg_n, frame_done, cfg_pending, cur_digit},
                 {m_an, m_seg, exp_fd(), m_pend, exp_cur()});
      end
    end
  endtask

  task automatic test_stop();
    cfg_t c;
    c = rnd_cfg(); c.en = 8'hFF; c.br = 2'd3;
    load(c);
    for (int i = 0; i < 2 * FR && m_pend; i++) step();
    for (int i = 0; i < 2 * FR && exp_cur() != 4; i++) step();
    load(rnd_cfg());
    for (int i = 0; i < 2 * FR && !(exp_cur() == 5 && m_t % P == 7); i++) step();
    scan_en = 1'b0;
    step();
    n_chk++;
    if ({an_n, seg_n, cur_digit, cfg_pending} !== {8'hFF, 8'hFF, 3'd0, 1'b0}) begin
      n_fail++; $display("FAIL stop_dark got=%h want=%h", {an_n, seg_n, cur_digit, cfg_pending}, {8'hFF, 8'hFF, 3'd0, 1'b0});
    end
    repeat (4) step();
    scan_en = 1'b1;
    for (int i = 0; i < FR + 4; i++) begin
      step();
      n_chk++;
      if ({an_n, seg_n, frame_done, cfg_pending, cur_digit} !== {m_an, m_seg, exp_fd(), m_pend, exp_cur()}) begin
        n_fail++;
        $display("FAIL restart t=%0d got=%h want=%h", m_t, {an_n, seg_n, frame_done, cfg_pending, cur_digit},
                 {m_an, m_seg, exp_fd(), m_pend, exp_cur()});
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < FR && exp_cur() != 3; i++) step();
    repeat (5) step();
    load(rnd_cfg());
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({an_n, seg_n, frame_done, cfg_pending} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL async_reset got=%h want=%h", {an_n, seg_n, frame_done, cfg_pending}, {8'hFF, 8'hFF, 1'b0, 1'b0});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FR + 4; i++) begin
      step();
      n_chk++;
      if ({an_n, seg_n, frame_done, cfg_pending, cur_digit} !== {m_an, m_seg, exp_fd(), m_pend, exp_cur()}) begin
        n_fail++;
        $display("FAIL post_reset t=%0d got=%h want=%h", m_t, {an_n, seg_n, frame_done, cfg_pending, cur_digit},
                 {m_an, m_seg, exp_fd(), m_pend, exp_cur()});
      end
    end
  endtask

  initial begin
    HEX = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();
    test_reset();
    test_basic();
    test_cfg_update();
    test_pwm();
    test_mask();
    test_back_to_back();
    test_stop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
